// File: rtl/div_controller.sv
// rtl/div_controller.sv - restoring-division control FSM (optional DIV_ZERO_CHECK_EN divide-by-zero short cut)
module div_controller #(
    parameter int WIDTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_a_msb,
    input  logic                         i_m_zero,
    output logic                         ld_am,
    output logic                         en_q,
    output logic                         ld_q,
    output logic                         sl_q,
    output logic                         sh_a,
    output logic                         sub_a,
    output logic                         add_a,
    output logic [$clog2(WIDTH+1)-1:0]   o_count,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_dbz
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_SUB,
        S_TEST,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   count_q;
    logic            dbz_q;
    logic            dbz_hit;

`ifdef DIV_ZERO_CHECK_EN
    assign dbz_hit = i_m_zero;
`else
    // Zero divisor falls through the normal sequence (Q = all ones, R = dividend).
    logic unused_m_zero;
    assign unused_m_zero = i_m_zero;
    assign dbz_hit       = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Count is visible as WIDTH from LOAD onwards and reaches 0 on the final TEST.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        count_q <= COUNT_INIT;
                        dbz_q   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (dbz_hit) begin
                        count_q <= '0;
                        dbz_q   <= 1'b1;
                    end
                end
                S_TEST: begin
                    if (count_q != '0) begin
                        count_q <= count_q - COUNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        ld_am     = 1'b0;
        en_q      = 1'b0;
        ld_q      = 1'b0;
        sl_q      = 1'b0;
        sh_a      = 1'b0;
        sub_a     = 1'b0;
        add_a     = 1'b0;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_am     = 1'b1;
                en_q      = 1'b1;
                o_busy    = 1'b1;
                state_nxt = dbz_hit ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                sh_a      = 1'b1;
                o_busy    = 1'b1;
                state_nxt = S_SUB;
            end
            S_SUB: begin
                sub_a     = 1'b1;
                o_busy    = 1'b1;
                state_nxt = S_TEST;
            end
            S_TEST: begin
                // A negative remainder means the subtract overshot: restore and shift in 0.
                ld_q      = 1'b1;
                sl_q      = ~i_a_msb;
                add_a     = i_a_msb;
                o_busy    = 1'b1;
                state_nxt = (count_q <= COUNT_ONE) ? S_DONE : S_SHIFT;
            end
            S_DONE: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_count = count_q;
    assign o_dbz   = dbz_q;

endmodule

// File: tb/tb_div_controller.sv
// tb/tb_div_controller.sv - scoreboard bench for div_controller with a restoring-division datapath model
module tb_div_controller;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 1);

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_start = 1'b0;
    logic i_a_msb;
    logic i_m_zero;
    logic ld_am, en_q, ld_q, sl_q, sh_a, sub_a, add_a;
    logic [CW-1:0] o_count;
    logic o_busy, o_done, o_dbz;

    div_controller #(.WIDTH(WIDTH)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_a_msb (i_a_msb),
        .i_m_zero(i_m_zero),
        .ld_am   (ld_am),
        .en_q    (en_q),
        .ld_q    (ld_q),
        .sl_q    (sl_q),
        .sh_a    (sh_a),
        .sub_a   (sub_a),
        .add_a   (add_a),
        .o_count (o_count),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_dbz   (o_dbz)
    );

    always #5 i_clk = ~i_clk;

    // Datapath model: A is one bit wider than the operands so its MSB is the sign.
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor  = '0;
    logic [WIDTH:0]   acc_a    = '0;
    logic [WIDTH-1:0] reg_m    = '0;
    logic [WIDTH-1:0] reg_q    = '0;

    assign i_a_msb  = acc_a[WIDTH];
    assign i_m_zero = (divisor == '0);

    always @(posedge i_clk) begin
        if (ld_am) begin
            acc_a <= '0;
            reg_m <= divisor;
        end
        if (en_q)  reg_q <= dividend;
        if (sh_a)  acc_a <= {acc_a[WIDTH-1:0], reg_q[WIDTH-1]};
        if (sub_a) acc_a <= acc_a - {1'b0, reg_m};
        if (add_a) acc_a <= acc_a + {1'b0, reg_m};
        if (ld_q)  reg_q <= {reg_q[WIDTH-2:0], sl_q};
    end

    typedef struct {
        int q;
        int r;
        int dbz;
        int lat;
        int sl;
        int add;
        int gap;
        bit chk_qr;
    } exp_t;

    exp_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int q, input int r, input int dbz, input int lat,
                                input int sl, input int add, input int gap, input bit chk_qr);
        exp_t e;
        e.q = q; e.r = r; e.dbz = dbz; e.lat = lat;
        e.sl = sl; e.add = add; e.gap = gap; e.chk_qr = chk_qr;
        return e;
    endfunction

    // Monitor: pops an expectation at each LOAD and scores it at DONE.
    int   cyc = 0;
    int   load_cyc = 0;
    int   last_done = -100;
    int   sl_cnt = 0;
    int   add_cnt = 0;
    int   n_loads = 0;
    int   n_dones = 0;
    bit   active = 1'b0;
    exp_t cur;

    always @(negedge i_clk) begin
        cyc++;
        if (int'(ld_am) + int'(sh_a) + int'(sub_a) + int'(add_a) > 1) begin
            check("onehot_datapath_ctrl", int'(ld_am) + int'(sh_a) + int'(sub_a) + int'(add_a), 1);
        end
        if (ld_am) begin
            n_loads++;
            if (exp_q.size() == 0) begin
                check("unexpected_load_queue_size", 0, 1);
                active = 1'b0;
            end else begin
                cur = exp_q.pop_front();
                active   = 1'b1;
                load_cyc = cyc;
                sl_cnt   = 0;
                add_cnt  = 0;
                if (cur.gap >= 0) check("done_to_load_gap", cyc - last_done, cur.gap);
            end
        end
        if (active && ld_q) begin
            sl_cnt  += int'(sl_q);
            add_cnt += int'(add_a);
        end
        if (o_done) begin
            n_dones++;
            last_done = cyc;
            if (!active) begin
                check("done_without_load", 0, 1);
            end else begin
                check("latency", cyc - load_cyc + 1, cur.lat);
                check("dbz", int'(o_dbz), cur.dbz);
                check("count_at_done", int'(o_count), 0);
                check("busy_at_done", int'(o_busy), 0);
                check("sl_q_ones", sl_cnt, cur.sl);
                check("add_a_ones", add_cnt, cur.add);
                if (cur.chk_qr) begin
                    check("quotient", int'(reg_q), cur.q);
                    check("remainder", int'(acc_a[WIDTH-1:0]), cur.r);
                end
                active = 1'b0;
            end
        end
    end

    task automatic wait_done();
        int k;
        for (k = 0; k < 100; k++) begin
            if (o_done) break;
            @(negedge i_clk);
        end
        if (k == 100) check("timeout_wait_done", 0, 1);
        @(negedge i_clk);
    endtask

    task automatic run_op(input int a, input int b, input exp_t e);
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        exp_q.push_back(e);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done();
    endtask

    initial begin
        int k;
        int base;
        repeat (2) @(negedge i_clk);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_dbz", int'(o_dbz), 0);
        check("rst_count", int'(o_count), 0);
        check("rst_ctrl", int'({ld_am, en_q, ld_q, sl_q, sh_a, sub_a, add_a}), 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        run_op(13, 3, mk(4, 1, 0, 14, 1, 3, -1, 1));
        check("idle_count_after_op", int'(o_count), 0);
        run_op(15, 1, mk(15, 0, 0, 14, 4, 0, -1, 1));
        run_op(2, 7, mk(0, 2, 0, 14, 0, 4, -1, 1));
`ifdef DIV_ZERO_CHECK_EN
        run_op(9, 0, mk(0, 0, 1, 2, 0, 0, -1, 0));
        repeat (3) @(negedge i_clk);
        check("dbz_held_in_idle", int'(o_dbz), 1);
        run_op(13, 3, mk(4, 1, 0, 14, 1, 3, -1, 1));
`else
        run_op(9, 0, mk(15, 9, 0, 14, 4, 0, -1, 1));
`endif

        // Back-to-back with i_start held high.
        dividend = WIDTH'(7);
        divisor  = WIDTH'(2);
        exp_q.push_back(mk(3, 1, 0, 14, 2, 2, -1, 1));
        exp_q.push_back(mk(3, 1, 0, 14, 2, 2, 2, 1));
        base = n_loads;
        i_start = 1'b1;
        for (k = 0; k < 100 && n_loads < base + 2; k++) @(negedge i_clk);
        if (k == 100) check("timeout_b2b_loads", n_loads - base, 2);
        i_start = 1'b0;
        base = n_dones;
        for (k = 0; k < 100 && n_dones < base + 1; k++) @(negedge i_clk);
        if (k == 100) check("timeout_b2b_done", n_dones - base, 1);
        repeat (3) @(negedge i_clk);

        // Start pulse during busy must be ignored.
        dividend = WIDTH'(6);
        divisor  = WIDTH'(4);
        exp_q.push_back(mk(1, 2, 0, 14, 1, 3, -1, 1));
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (4) @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done();
        repeat (20) @(negedge i_clk);

        // Reset during the second SUB, with start held through reset.
        dividend = WIDTH'(13);
        divisor  = WIDTH'(3);
        exp_q.push_back(mk(4, 1, 0, 14, 1, 3, -1, 1));
        exp_q.push_back(mk(4, 1, 0, 14, 1, 3, -1, 1));
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        base = 0;
        for (k = 0; k < 100 && base < 2; k++) begin
            if (sub_a) base++;
            if (base < 2) @(negedge i_clk);
        end
        if (k == 100) check("timeout_second_sub", base, 2);
        i_rst   = 1'b1;
        i_start = 1'b1;
        @(negedge i_clk);
        check("midrst_busy", int'(o_busy), 0);
        check("midrst_done", int'(o_done), 0);
        check("midrst_dbz", int'(o_dbz), 0);
        check("midrst_count", int'(o_count), 0);
        check("midrst_ctrl", int'({ld_am, en_q, ld_q, sl_q, sh_a, sub_a, add_a}), 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        i_start = 1'b0;
        check("start_after_rst_load", int'(ld_am), 1);
        wait_done();

        repeat (20) @(negedge i_clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
